// File: rtl/sram_rtlc_initiator.sv
// Valid/ready initiator for a single-port synchronous SRAM with a credit-sized, in-order read response FIFO.
// Optional write acknowledgements are enabled by defining SRAM_RTLC_WRACK_EN.
module sram_rtlc_initiator #(
    parameter int WORD_SIZE  = 256,
    parameter int NUM_WORDS  = 128,
    parameter int WRITE_SIZE = 8,
    parameter int READ_LAT   = 2,
    parameter int RSP_DEPTH  = 4,
    parameter int ID_W       = 4,
    localparam int ADDR_W    = $clog2(NUM_WORDS),
    localparam int WM_W      = WORD_SIZE / WRITE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_req_valid,
    output logic                 OUT_req_ready,
    input  logic                 IN_req_we,
    input  logic [ADDR_W-1:0]    IN_req_addr,
    input  logic [WORD_SIZE-1:0] IN_req_data,
    input  logic [WM_W-1:0]      IN_req_wm,
    input  logic [ID_W-1:0]      IN_req_id,
    output logic                 OUT_sram_nce,
    output logic                 OUT_sram_nwe,
    output logic [ADDR_W-1:0]    OUT_sram_addr,
    output logic [WORD_SIZE-1:0] OUT_sram_data,
    output logic [WM_W-1:0]      OUT_sram_wm,
    input  logic [WORD_SIZE-1:0] IN_sram_data,
    output logic                 OUT_rsp_valid,
    input  logic                 IN_rsp_ready,
    output logic [WORD_SIZE-1:0] OUT_rsp_data,
    output logic [ID_W-1:0]      OUT_rsp_id,
    output logic                 OUT_rsp_we
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic                 accept;
    logic                 credit_take;
    logic                 pop;
    logic                 push;
    logic [WORD_SIZE-1:0] push_data;
    logic [CNT_W-1:0]     used;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Ready depends only on registered credit state and rst, never on IN_req_*.
    assign OUT_req_ready = !rst && (used < CNT_W'(RSP_DEPTH));
    assign accept        = IN_req_valid && OUT_req_ready;
    assign pop           = OUT_rsp_valid && IN_rsp_ready;
`ifdef SRAM_RTLC_WRACK_EN
    assign credit_take   = accept;
`else
    assign credit_take   = accept && !IN_req_we;
`endif

    // Credits cover in-flight reads plus FIFO occupancy, so a push always finds space.
    always_ff @(posedge clk) begin
        if (rst) begin
            used <= '0;
        end else if (credit_take && !pop) begin
            used <= used + CNT_W'(1);
        end else if (!credit_take && pop) begin
            used <= used - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_sram_nce  <= 1'b1;
            OUT_sram_nwe  <= 1'b1;
            OUT_sram_addr <= '0;
            OUT_sram_data <= '0;
            OUT_sram_wm   <= '0;
        end else begin
            OUT_sram_nce <= !accept;
            OUT_sram_nwe <= !(accept && IN_req_we);
            if (accept) begin
                OUT_sram_addr <= IN_req_addr;
            end
            if (accept && IN_req_we) begin
                OUT_sram_data <= IN_req_data;
                OUT_sram_wm   <= IN_req_wm;
            end
        end
    end

    // Stage 0 lines up with the pin cycle; the last stage lines up with valid SRAM read data.
    logic [READ_LAT:0] pipe_valid;
    logic [ID_W-1:0]   pipe_id [READ_LAT+1];
`ifdef SRAM_RTLC_WRACK_EN
    logic [READ_LAT:0] pipe_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid <= {pipe_valid[READ_LAT-1:0], credit_take};
        end
    end

    always_ff @(posedge clk) begin
        pipe_id[0] <= IN_req_id;
        for (int i = 1; i <= READ_LAT; i++) begin
            pipe_id[i] <= pipe_id[i-1];
        end
`ifdef SRAM_RTLC_WRACK_EN
        pipe_we <= {pipe_we[READ_LAT-1:0], IN_req_we};
`endif
    end

    assign push = pipe_valid[READ_LAT];
`ifdef SRAM_RTLC_WRACK_EN
    assign push_data = pipe_we[READ_LAT] ? '0 : IN_sram_data;
`else
    assign push_data = IN_sram_data;
`endif

    logic [WORD_SIZE-1:0] mem_data [RSP_DEPTH];
    logic [ID_W-1:0]      mem_id   [RSP_DEPTH];
`ifdef SRAM_RTLC_WRACK_EN
    logic                 mem_we   [RSP_DEPTH];
`endif
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_id[wr_ptr]   <= pipe_id[READ_LAT];
`ifdef SRAM_RTLC_WRACK_EN
            mem_we[wr_ptr]   <= pipe_we[READ_LAT];
`endif
        end
    end

    assign OUT_rsp_valid = (count != '0);
    assign OUT_rsp_data  = mem_data[rd_ptr];
    assign OUT_rsp_id    = mem_id[rd_ptr];
`ifdef SRAM_RTLC_WRACK_EN
    assign OUT_rsp_we    = mem_we[rd_ptr];
`else
    assign OUT_rsp_we    = 1'b0;
`endif

endmodule

// File: doc/sram_rtlc_initiator.md
Name: sram_rtlc_initiator

Overview:
- Initiator/controller for the single-port synchronous SRAM macro interface: active-low chip enable and write enable, byte write mask, and 2-cycle read latency (input register, then output register).
- Accepts valid/ready requests from a client (cache/LSU side) and drives the SRAM pins from flops.
- Tracks in-flight reads and captures read data into an in-order response FIFO.
- Sized by credits so read data is never dropped while the client stalls.

Parameters:
- WORD_SIZE, 256, SRAM word width in bits.
- NUM_WORDS, 128, SRAM depth; ADDR_W = $clog2(NUM_WORDS).
- WRITE_SIZE, 8, write-mask granularity in bits; WM_W = WORD_SIZE/WRITE_SIZE.
- READ_LAT, 2, cycles from the SRAM pins showing nce=0/nwe=1 to OUT_data becoming valid.
- RSP_DEPTH, 4, response FIFO entries; also the maximum reads outstanding plus buffered.
- ID_W, 4, request tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- IN_req_valid  in  1  request valid
- OUT_req_ready  out  1  request accepted when valid&ready
- IN_req_we  in  1  1=write, 0=read
- IN_req_addr  in  ADDR_W  word address
- IN_req_data  in  WORD_SIZE  write data
- IN_req_wm  in  WM_W  write byte mask
- IN_req_id  in  ID_W  tag echoed on the response
- OUT_sram_nce  out  1  SRAM chip enable, active-low
- OUT_sram_nwe  out  1  SRAM write enable, active-low
- OUT_sram_addr  out  ADDR_W  SRAM address
- OUT_sram_data  out  WORD_SIZE  SRAM write data
- OUT_sram_wm  out  WM_W  SRAM write mask
- IN_sram_data  in  WORD_SIZE  SRAM read data
- OUT_rsp_valid  out  1  response valid
- IN_rsp_ready  in  1  response consumed when valid&ready
- OUT_rsp_data  out  WORD_SIZE  read data
- OUT_rsp_id  out  ID_W  echoed tag
- OUT_rsp_we  out  1  1 = write ack (feature only), else 0

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - OUT_sram_nce=1, OUT_sram_nwe=1; OUT_sram_addr, OUT_sram_data and OUT_sram_wm = 0.
  - Tracking pipe cleared, FIFO emptied, credit counter = 0, OUT_rsp_valid=0.
  - OUT_req_ready=0 while rst=1.
- Reset mid-operation: in-flight reads are discarded; no response appears for them after reset.
- Credits: used = in-flight reads + FIFO occupancy.
  - OUT_req_ready = !rst && (used < RSP_DEPTH); registered-state-only, no combinational path from IN_req_*.
  - Accept of a read: used+1. Response pop: used-1. Both in the same cycle: unchanged.
  - Writes consume no credit (except with the feature).
- Issue: a request accepted in cycle T drives the SRAM pins in cycle T+1.
  - Read: nce=0, nwe=1.
  - Write: nce=0, nwe=0, plus addr/data/wm.
  - No accept in T: cycle T+1 has nce=1, nwe=1, and addr/data/wm hold their previous values.
- Back-to-back requests issue one per cycle, with no bubbles.
- Read tracking: a shift register of READ_LAT+1 stages carries {valid, id, we}, loaded at issue.
  - IN_sram_data is sampled in cycle T+1+READ_LAT (T+3 at default) and pushed into the FIFO at that edge.
  - OUT_rsp_valid rises in cycle T+2+READ_LAT (T+4 at default).
- FIFO: RSP_DEPTH entries, circular read/write pointers with wrap-around at RSP_DEPTH-1 -> 0.
  - Outputs come from the head entry; responses are strictly in issue order.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Overflow is impossible by construction of the credit counter; the bench asserts it.
- Read-after-write to the same address, issued back-to-back, returns the new data; SRAM ordering guarantees this and no forwarding logic is required.
- The controller never issues a write and a read in the same cycle (single port).

Optional Feature:
- Macro SRAM_RTLC_WRACK_EN.
- Defined:
  - Writes consume a credit like reads.
  - Each write produces a response, in order, with OUT_rsp_we=1, OUT_rsp_data=0 and the echoed id, at the same T+4 timing.
- Undefined:
  - Writes are fire-and-forget; OUT_rsp_we is tied to 0.

Test Plan:
- Single read: SRAM word 5 preloaded with 0xA5..A5; read addr 5, id=3 accepted at T.
  - Required: OUT_sram_nce=0, nwe=1 at T+1; rsp_valid at T+4 with data 0xA5..A5, id=3.
- Write then read: write addr 9 data 0xFF..FF wm=0x...0001 at T, then read addr 9 at T+1 on a zeroed SRAM.
  - Required: read response has byte0=0xFF and all other bytes 0.
- Stall: IN_rsp_ready=0, issue 6 back-to-back reads, ids 0..5.
  - Required: ready drops after the 4th accept.
  - Then raise rsp_ready: responses arrive as ids 0,1,2,3 in order, followed by 4,5 after they are accepted.
- Full with simultaneous pop and accept: FIFO full, rsp_ready=1 with a read pending.
  - Required: ready reasserts the cycle after the pop; no loss or duplication across 20 random cycles with pointer wrap.
- Reset mid-flight: issue 2 reads, assert rst at T+2 for one cycle.
  - Required: no rsp_valid afterward, nce=1, and ready=1 the cycle after rst falls.
- SRAM_RTLC_WRACK_EN: write id=7 at T.
  - Required: response at T+4 with rsp_we=1, id=7, data=0; with the macro undefined, no response.
